// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state, constants and request record for the memory bus arbiter
package mem_bus_pkg;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam logic [3:0] BE_ALL = 4'hF;
  typedef enum logic [1:0] {IDLE, INSTR, DATA} arb_state_t;
  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic              we;
    logic [BUS_DW-1:0] wdata;
    logic [3:0]        be;
  } bus_req_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: Avalon-style single-port memory bus
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;
  logic [BUS_AW-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [BUS_DW-1:0] m_writedata;
  logic [3:0]        m_byteenable;
  logic [BUS_DW-1:0] m_readdata;
  logic              m_waitrequest;
  modport master (
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_readdata, m_waitrequest
  );
  modport slave (
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_readdata, m_waitrequest
  );
endinterface

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: counts stalled bus cycles and flags the cycle that reaches MAX_WAIT (0 = never)
module arb_wait_counter #(
  parameter int MAX_WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 16'd1;
  assign expired = MAX_WAIT != 0 && enable && cnt == 16'(MAX_WAIT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon-style memory bus between the instruction and data ports.
// Define ARB_ALIGN_CHECK_EN to reject word-misaligned requests with a misaligned pulse.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1,
  parameter int MAX_WAIT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [BUS_AW-1:0] i_addr,
  output logic [BUS_DW-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BUS_AW-1:0] d_addr,
  input  logic [BUS_DW-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [BUS_DW-1:0] d_rdata,
  output logic              d_done,
  mem_bus_arbiter_if.master bus,
  output logic              busy,
  output logic              abort
`ifdef ARB_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);
  arb_state_t state, state_nx;
  bus_req_t req_q;
  logic ir, dr, pick_i, pick_d, go, bad, ack, expired;
  // a requester whose done is showing is masked so the other side gets the next turn
  assign ir = i_req && !i_done;
  assign dr = d_req && !d_done;
  assign pick_d = dr && (DATA_PRIORITY || !ir);
  assign pick_i = ir && !pick_d;
  assign go = state == IDLE && (pick_i || pick_d);
`ifdef ARB_ALIGN_CHECK_EN
  assign bad = (pick_d ? d_addr[1:0] : i_addr[1:0]) != 2'b00;
`else
  assign bad = 1'b0;
`endif
  assign ack = state != IDLE && !bus.m_waitrequest;
  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk,
    .reset,
    .clear(state == IDLE),
    .enable(state != IDLE && bus.m_waitrequest),
    .expired
  );
  always_comb begin
    state_nx = state;
    if (go && !bad) state_nx = pick_d ? DATA : INSTR;
    else if (ack || expired) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      req_q   <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      abort   <= 1'b0;
    end else begin
      if (go && !bad) req_q <= pick_d ? {d_addr, d_we, d_wdata, d_be} : {i_addr, 1'b0, {BUS_DW{1'b0}}, BE_ALL};
      i_done <= ((ack || expired) && state == INSTR) || (go && bad && pick_i);
      d_done <= ((ack || expired) && state == DATA) || (go && bad && pick_d);
      abort  <= expired;
      if (ack && state == INSTR) i_rdata <= bus.m_readdata;
      else if (go && bad && pick_i) i_rdata <= '0;
      if (ack && state == DATA && !req_q.we) d_rdata <= bus.m_readdata;
      else if (go && bad && pick_d) d_rdata <= '0;
    end
`ifdef ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) misaligned <= 1'b0;
    else misaligned <= go && bad;
`endif
  assign bus.m_address    = req_q.addr;
  assign bus.m_writedata  = req_q.wdata;
  assign bus.m_byteenable = req_q.be;
  assign bus.m_read       = state == INSTR || (state == DATA && !req_q.we);
  assign bus.m_write      = state == DATA && req_q.we;
  // busy also covers the done cycle so a whole transaction reads as one busy window
  assign busy = state != IDLE || i_done || d_done;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int MW = 4;
`ifdef ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
  logic misaligned;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, i_done, d_done, busy, abort;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, i_rdata, d_rdata;
  logic [3:0] d_be = '0;
  int checks = 0, errors = 0, wait_cnt = 0;
  bit stuck = 1'b0, rnd_wait = 1'b0;
  logic [31:0] mem [logic [29:0]];
  mem_bus_arbiter_if bus();
  mem_bus_arbiter #(.DATA_PRIORITY(1'b1), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .bus(bus), .busy(busy), .abort(abort)
`ifdef ARB_ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : a ^ 32'h5A5A0F0F;
  endfunction
  function automatic void wr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    logic [31:0] w = rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[a[31:2]] = w;
  endfunction
  function automatic logic [31:0] raddr();
    logic [31:0] a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if (ALIGN && $urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask
  // model: who owns the bus, how long it has stalled, and what each requester should see next cycle
  typedef struct packed {
    logic [1:0] owner;
    int waits;
    logic [31:0] addr;
    logic we;
    logic [31:0] wdata;
    logic [3:0] be;
    logic idone, ddone, abort, mis;
    logic [31:0] irdata, drdata;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t nxt(mdl_t s);
    mdl_t n = s;
    logic ir = i_req && !s.idone, dr = d_req && !s.ddone;
    logic [1:0] win = (dr) ? 2'd2 : ir ? 2'd1 : 2'd0;
    logic [31:0] wa = win == 2'd2 ? d_addr : i_addr;
    n.idone = 1'b0; n.ddone = 1'b0; n.abort = 1'b0; n.mis = 1'b0;
    if (s.owner == 2'd0 && win != 2'd0) begin
      if (ALIGN && wa[1:0] != 2'b00) begin
        n.mis = 1'b1; n.idone = win == 2'd1; n.ddone = win == 2'd2;
        if (win == 2'd1) n.irdata = '0; else n.drdata = '0;
      end else begin
        n.owner = win; n.waits = 0; n.addr = wa; n.we = win == 2'd2 && d_we;
        n.wdata = d_wdata; n.be = win == 2'd2 ? d_be : 4'hF;
      end
    end else if (s.owner != 2'd0) begin
      if (!bus.m_waitrequest || s.waits + 1 == MW) begin
        if (!bus.m_waitrequest && s.owner == 2'd1) n.irdata = rd(s.addr);
        if (!bus.m_waitrequest && s.owner == 2'd2 && !s.we) n.drdata = rd(s.addr);
        n.abort = bus.m_waitrequest;
        n.idone = s.owner == 2'd1; n.ddone = s.owner == 2'd2; n.owner = 2'd0;
      end else n.waits = s.waits + 1;
    end
    return n;
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) m <= '0;
    else m <= nxt(m);
  always @(negedge clk) if (reset) begin
    chk("i_done", 32'(i_done), 32'(m.idone));
    chk("d_done", 32'(d_done), 32'(m.ddone));
    chk("abort", 32'(abort), 32'(m.abort));
    chk("busy", 32'(busy), 32'(m.owner != 2'd0 || m.idone || m.ddone));
    chk("i_rdata", i_rdata, m.irdata);
    chk("d_rdata", d_rdata, m.drdata);
    chk("m_read", 32'(bus.m_read), 32'(m.owner == 2'd1 || (m.owner == 2'd2 && !m.we)));
    chk("m_write", 32'(bus.m_write), 32'(m.owner == 2'd2 && m.we));
    if (m.owner != 2'd0) begin
      chk("m_address", bus.m_address, m.addr);
      chk("m_byteenable", 32'(bus.m_byteenable), 32'(m.be));
      if (m.we) chk("m_writedata", bus.m_writedata, m.wdata);
    end
`ifdef ARB_ALIGN_CHECK_EN
    chk("misaligned", 32'(misaligned), 32'(m.mis));
`endif
  end
  // one cycle of bus slave behaviour, leaving the caller just after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
    if ((bus.m_read || bus.m_write) && wait_cnt > 0) begin
      bus.m_waitrequest = 1'b1;
      wait_cnt--;
    end else bus.m_waitrequest = stuck || (rnd_wait && $urandom_range(0, 2) == 0);
    bus.m_readdata = bus.m_waitrequest ? $urandom : rd(bus.m_address);
    if (bus.m_write && !bus.m_waitrequest) wr(bus.m_address, bus.m_writedata, bus.m_byteenable);
  endtask
  initial begin
    bus.m_waitrequest = 1'b0;
    bus.m_readdata = '0;
    wr(32'hBFC00000, 32'h24020005, 4'hF);
    wr(32'hBFC00004, 32'h8C430000, 4'hF);
    wr(32'hBFC00008, 32'h11112222, 4'hF);
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_read", 32'(bus.m_read), 32'd0);
    chk("rst_i_done", 32'(i_done), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_m_address", bus.m_address, 32'd0);
    reset = 1'b1;
    step();
    // plain fetch, zero wait
    i_req = 1'b1; i_addr = 32'hBFC00000;
    step();
    chk("t1_m_read", 32'(bus.m_read), 32'd1);
    chk("t1_busy_a", 32'(busy), 32'd1);
    chk("t1_addr", bus.m_address, 32'hBFC00000);
    step();
    chk("t1_i_done", 32'(i_done), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h24020005);
    chk("t1_busy_b", 32'(busy), 32'd1);
    i_req = 1'b0;
    step();
    chk("t1_busy_c", 32'(busy), 32'd0);
    // simultaneous requests: data write goes first
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00001000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    step();
    chk("t2_m_write", 32'(bus.m_write), 32'd1);
    chk("t2_m_read", 32'(bus.m_read), 32'd0);
    chk("t2_addr", bus.m_address, 32'h00001000);
    chk("t2_wdata", bus.m_writedata, 32'hDEADBEEF);
    step();
    chk("t2_d_done", 32'(d_done), 32'd1);
    chk("t2_i_done", 32'(i_done), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    chk("t2_fetch_read", 32'(bus.m_read), 32'd1);
    chk("t2_fetch_addr", bus.m_address, 32'hBFC00000);
    step();
    chk("t2_fetch_done", 32'(i_done), 32'd1);
    i_req = 1'b0;
    step();
    // data read with three stall cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00001000; wait_cnt = 3;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t3_addr_hold", bus.m_address, 32'h00001000);
      chk("t3_no_done", 32'(d_done), 32'd0);
    end
    step();
    chk("t3_d_done", 32'(d_done), 32'd1);
    chk("t3_d_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    step();
    // stuck waitrequest hits MAX_WAIT
    i_req = 1'b1; i_addr = 32'hBFC00008; stuck = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t4_read_held", 32'(bus.m_read), 32'd1);
    end
    step();
    chk("t4_read_drop", 32'(bus.m_read), 32'd0);
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_i_done", 32'(i_done), 32'd1);
    chk("t4_rdata_kept", i_rdata, 32'h24020005);
    i_req = 1'b0; stuck = 1'b0;
    step();
    chk("t4_abort_off", 32'(abort), 32'd0);
    i_req = 1'b1; i_addr = 32'hBFC00004;
    step();
    step();
    chk("t4_next_done", 32'(i_done), 32'd1);
    chk("t4_next_rdata", i_rdata, 32'h8C430000);
    i_req = 1'b0;
    step();
    // reset in the middle of a stalled data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00001000; stuck = 1'b1;
    step();
    step();
    chk("t5_in_wait", 32'(bus.m_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_read_low", 32'(bus.m_read), 32'd0);
    chk("t5_write_low", 32'(bus.m_write), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    d_req = 1'b0; stuck = 1'b0;
    step();
    chk("t5_no_done_a", 32'(d_done), 32'd0);
    reset = 1'b1;
    step();
    chk("t5_no_done_b", 32'(d_done), 32'd0);
    i_req = 1'b1; i_addr = 32'hBFC00000;
    step();
    step();
    chk("t5_fetch_done", 32'(i_done), 32'd1);
    chk("t5_fetch_rdata", i_rdata, 32'h24020005);
    i_req = 1'b0;
    step();
`ifdef ARB_ALIGN_CHECK_EN
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00001002;
    step();
    chk("t6_d_done", 32'(d_done), 32'd1);
    chk("t6_misaligned", 32'(misaligned), 32'd1);
    chk("t6_d_rdata", d_rdata, 32'd0);
    chk("t6_no_strobe", 32'(bus.m_read || bus.m_write), 32'd0);
    d_req = 1'b0;
    step();
`endif
    // randomized traffic with random stalls, occasionally long enough to abort
    rnd_wait = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (i_done || !i_req) begin
        i_req = 1'($urandom_range(0, 1));
        i_addr = raddr();
      end
      if (d_done || !d_req) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = raddr();
        d_wdata = $urandom;
        d_be = 4'($urandom_range(1, 15));
      end
    end
    rnd_wait = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
    chk("end_idle", 32'(busy || i_req || d_req), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
